// File: rtl/mem_copy_engine_if.sv
// Handshake and memory-port bundle for mem_copy_engine.
//   master : the copy engine (drives status and the memory port, receives request and read data)
//   slave  : the requester/memory side (drives request and read data, observes the rest)
interface mem_copy_engine_if #(
    parameter int unsigned LEN_W = 6
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic              err;
    logic [LEN_W-1:0]  count;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_read_data;

    modport master (
        input  start, src_addr, dst_addr, len, mem_read_data,
        output busy, done, err, count, mem_address, mem_write_data, mem_write, mem_read
    );

    modport slave (
        output start, src_addr, dst_addr, len, mem_read_data,
        input  busy, done, err, count, mem_address, mem_write_data, mem_write, mem_read
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Block copy engine: moves len words from src_addr to dst_addr over the data-memory port,
// one read cycle then one write cycle per word, ascending addresses.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : mem_copy_engine_if.master
//                request  : start, src_addr, dst_addr, len
//                status   : busy, done (1-cycle pulse), err (held until next start), count
//                memory   : mem_address, mem_write_data, mem_write, mem_read, mem_read_data
module mem_copy_engine #(
    parameter int unsigned BANK_WORDS = 20,
    parameter int unsigned LEN_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_copy_engine_if.master     bus
);
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned BANK_STEP = 1000;
    localparam int unsigned NUM_BANKS = 3;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RD,
        WR,
        FIN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] hold_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              rd_q;
    logic              wr_q;

    logic [LEN_W-1:0]  cnt_nxt_c;
    logic              legal_c;

    // True when [base, base+n-1] sits entirely inside one bank; 33-bit ends avoid wrap.
    function automatic logic range_ok(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] n);
        logic [ADDR_W:0] lo;
        logic [ADDR_W:0] hi;
        logic            ok;
        lo = {1'b0, base};
        hi = lo + (ADDR_W+1)'(n) - (ADDR_W+1)'(1);
        ok = 1'b0;
        for (int unsigned b = 1; b <= NUM_BANKS; b++) begin
            if ((lo >= (ADDR_W+1)'(b * BANK_STEP)) &&
                (hi <= (ADDR_W+1)'(b * BANK_STEP + BANK_WORDS - 1))) begin
                ok = 1'b1;
            end
        end
        return ok;
    endfunction

    assign cnt_nxt_c = cnt_q + LEN_W'(1);
    assign legal_c   = (len_q != '0) && range_ok(src_q, len_q) && range_ok(dst_q, len_q);

    // Control FSM; every output comes straight from a register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            addr_q <= '0;
            hold_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        src_q  <= bus.src_addr;
                        dst_q  <= bus.dst_addr;
                        len_q  <= bus.len;
                        err_q  <= 1'b0;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (legal_c) begin
                        addr_q <= src_q;
                        rd_q   <= 1'b1;
                        state  <= RD;
                    end else begin
                        err_q  <= 1'b1;
                        state  <= FIN;
                    end
                end
                RD: begin
                    // hold_q doubles as the write-data register, so it only moves on entry to WR
                    hold_q <= bus.mem_read_data;
                    addr_q <= dst_q + ADDR_W'(cnt_q);
                    rd_q   <= 1'b0;
                    wr_q   <= 1'b1;
                    state  <= WR;
                end
                WR: begin
                    cnt_q <= cnt_nxt_c;
                    wr_q  <= 1'b0;
                    if (cnt_nxt_c == len_q) begin
                        state <= FIN;
                    end else begin
                        addr_q <= src_q + ADDR_W'(cnt_nxt_c);
                        rd_q   <= 1'b1;
                        state  <= RD;
                    end
                end
                FIN: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    rd_q   <= 1'b0;
                    wr_q   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.err            = err_q;
    assign bus.count          = cnt_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_write_data = hold_q;
    assign bus.mem_write      = wr_q;
    assign bus.mem_read       = rd_q;
endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: directed transfers push their expected completion
// (err, count, latency) into a queue; a monitor pops and compares on each done pulse.
module tb_mem_copy_engine;
    localparam int unsigned LEN_W = 6;

    typedef struct {
        string name;
        logic  err;
        int    cnt;
        int    lat;
        int    t0;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   wr_cnt = 0;
    int   rd_cnt = 0;
    exp_t exp_q[$];
    logic [31:0] mem [0:4095];

    mem_copy_engine_if #(.LEN_W(LEN_W)) bus ();

    mem_copy_engine #(.BANK_WORDS(20), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Background fill pattern for every word not explicitly preloaded.
    function automatic logic [31:0] f(input int a);
        return 32'h5A00_0000 | 32'(a);
    endfunction

    // Data memory: combinational read, commit on negedge.
    assign bus.mem_read_data = (bus.mem_address < 32'd4096) ? mem[bus.mem_address[11:0]] : 32'h0;
    always @(negedge clk) begin
        if (bus.mem_write) begin
            wr_cnt = wr_cnt + 1;
            if (bus.mem_address < 32'd4096) mem[bus.mem_address[11:0]] = bus.mem_write_data;
        end
        if (bus.mem_read) rd_cnt = rd_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: compare each done pulse against the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            check("rd_wr_exclusive", 32'(bus.mem_read & bus.mem_write), 32'd0);
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1, required no pending transfer");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check({e.name, "_err"}, 32'(bus.err), 32'(e.err));
                    check({e.name, "_count"}, 32'(bus.count), 32'(e.cnt));
                    check({e.name, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
                end
            end
        end
    end

    task automatic launch(input string name, input int src, input int dst, input int n,
                          input logic e_err, input int e_cnt, input int e_lat);
        exp_t e;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.src_addr = 32'(src);
        bus.dst_addr = 32'(dst);
        bus.len      = LEN_W'(n);
        @(negedge clk);
        bus.start = 1'b0;
        e.name = name;
        e.err  = e_err;
        e.cnt  = e_cnt;
        e.lat  = e_lat;
        e.t0   = cyc;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        int wr0;
        int rd0;
        bit hit;
        logic [31:0] t1_data [4];
        t1_data[0] = 32'h0000_000A;
        t1_data[1] = 32'h0000_000B;
        t1_data[2] = 32'h0000_000C;
        t1_data[3] = 32'h0000_000D;

        for (int i = 0; i < 4096; i++) mem[i] = f(i);
        for (int i = 0; i < 4; i++) mem[1000 + i] = t1_data[i];
        bus.start    = 1'b0;
        bus.src_addr = 32'h0;
        bus.dst_addr = 32'h0;
        bus.len      = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_mem_rw", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        check("rst_addr", bus.mem_address, 32'd0);
        check("rst_wdata", bus.mem_write_data, 32'd0);
        rst_n = 1'b1;

        // 1: basic 4-word copy into bank 2
        launch("t1", 1000, 2005, 4, 1'b0, 4, 10);
        wait_done("t1", 30);
        for (int i = 0; i < 4; i++) check($sformatf("t1_word%0d", i), mem[2005 + i], t1_data[i]);
        check("t1_below", mem[2004], f(2004));
        check("t1_above", mem[2009], f(2009));

        // 2: source crosses end of bank 1
        wr0 = wr_cnt; rd0 = rd_cnt;
        launch("t2", 1018, 2000, 3, 1'b1, 0, 2);
        wait_done("t2", 10);
        check("t2_no_write", 32'(wr_cnt - wr0), 32'd0);
        check("t2_no_read", 32'(rd_cnt - rd0), 32'd0);
        check("t2_mem_unchanged", mem[2000], f(2000));

        // 3: zero length, then destination outside every bank
        wr0 = wr_cnt; rd0 = rd_cnt;
        launch("t3a", 1000, 2000, 0, 1'b1, 0, 2);
        wait_done("t3a", 10);
        launch("t3b", 1000, 1500, 2, 1'b1, 0, 2);
        wait_done("t3b", 10);
        check("t3_no_access", 32'((wr_cnt - wr0) + (rd_cnt - rd0)), 32'd0);
        check("t3_err_held", 32'(bus.err), 32'd1);

        // 5: repeated start while busy is ignored
        launch("t5", 1010, 2000, 3, 1'b0, 3, 8);
        @(negedge clk);
        check("t5_busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b1; bus.src_addr = 32'd3000; bus.dst_addr = 32'd1000; bus.len = LEN_W'(1);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("t5", 20);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++) check($sformatf("t5_word%0d", i), mem[2000 + i], f(1010 + i));
        check("t5_ignored_untouched", mem[1000], 32'h0000_000A);

        // 4: reset after the second word of a 5-word copy
        launch("t4", 1005, 2010, 5, 1'b0, 5, 12);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (bus.count == LEN_W'(2)) hit = 1'b1;
        end
        check("t4_reached_two", 32'(hit), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        exp_q.delete();
        check("t4_rst_status", {28'd0, bus.busy, bus.done, bus.err, 1'b0}, 32'd0);
        check("t4_rst_count", 32'(bus.count), 32'd0);
        check("t4_rst_mem_rw", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        check("t4_rst_addr", bus.mem_address, 32'd0);
        check("t4_rst_wdata", bus.mem_write_data, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_word0", mem[2010], f(1005));
        check("t4_word1", mem[2011], f(1006));
        for (int i = 2; i < 5; i++) check($sformatf("t4_untouched%0d", i), mem[2010 + i], f(2010 + i));
        launch("t4_restart", 1015, 2016, 1, 1'b0, 1, 4);
        wait_done("t4_restart", 10);
        check("t4_restart_word", mem[2016], f(1015));

        // 6: full-bank copy bank 3 -> bank 1
        launch("t6", 3000, 1000, 20, 1'b0, 20, 42);
        wait_done("t6", 60);
        for (int i = 0; i < 20; i++) check($sformatf("t6_word%0d", i), mem[1000 + i], f(3000 + i));

        repeat (3) @(negedge clk);
        check("pending_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
